// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: the NOP encoding and the instruction feeder state type.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO without fall-through; read data is the current head entry.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit separates the full and empty cases when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage has no reset; emptiness is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/cpu_instr_feeder.sv
// Issues buffered instruction words to the CPU, pads with NOPs and returns tagged results.
// Optional FEEDER_ECHO_EN adds res_instr, the issued word echoed alongside each result.
module cpu_instr_feeder
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   parameter int LAT   = 1,
   parameter int TAGW  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   output logic [XLEN-1:0] cpu_instr,
   input  logic [XLEN-1:0] cpu_result,
   output logic            res_valid,
   output logic [XLEN-1:0] res_data,
   output logic [TAGW-1:0] res_tag,
`ifdef FEEDER_ECHO_EN
   output logic [XLEN-1:0] res_instr,
`endif
   output logic            busy
);

   localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INSTR);

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
`ifdef FEEDER_ECHO_EN
      logic [XLEN-1:0] instr;
`endif
   } inflight_t;

   feeder_state_t   state;
   feeder_state_t   state_nxt;
   inflight_t       pipe [LAT];
   logic [TAGW-1:0] issue_cnt;
   logic            pipe_busy;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [XLEN-1:0] fifo_rdata;
   logic [XLEN-1:0] issue_word;

   sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (fifo_pop),
      .wdata (in_instr),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign busy     = (state != IDLE) || !fifo_empty;

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < LAT; i++)
         pipe_busy = pipe_busy | pipe[i].valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run) state_nxt = RUN;
         RUN:     if (!run) state_nxt = DRAIN;
         DRAIN:   if (run) state_nxt = RUN;
                  else if (!pipe_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Issue stops on the very edge run falls, so queued words stay in the FIFO.
   always_comb begin
      fifo_pop   = (state == RUN) && run && !fifo_empty;
      issue_word = fifo_pop ? fifo_rdata : NOP_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_instr <= NOP_W;
         issue_cnt <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
`ifdef FEEDER_ECHO_EN
         res_instr <= NOP_W;
`endif
         for (int i = 0; i < LAT; i++)
            pipe[i] <= '0;
      end else begin
         cpu_instr <= issue_word;
         if (fifo_pop)
            issue_cnt <= issue_cnt + TAGW'(1);

         pipe[0].valid <= fifo_pop;
         pipe[0].tag   <= issue_cnt;
`ifdef FEEDER_ECHO_EN
         pipe[0].instr <= issue_word;
`endif
         for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];

         // The oldest slot lines up with the CPU's Result for that instruction.
         res_valid <= pipe[LAT-1].valid;
         if (pipe[LAT-1].valid) begin
            res_data <= cpu_result;
            res_tag  <= pipe[LAT-1].tag;
`ifdef FEEDER_ECHO_EN
            res_instr <= pipe[LAT-1].instr;
`endif
         end
      end
   end

endmodule
